// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 serial driver.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DIV_MIN = 2;

  // A single-bit counter is still needed when only one bit is sent.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/hc595_phase.sv
// Phase timer: counts 0..DIV-1 and flags the first and last cycle of each phase.
module hc595_phase
  import hc595_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_reload,
  output logic o_phase_start,
  output logic o_phase_end
);

  // DIV below DIV_MIN would put the SER update on the SRCLK rising edge.
  localparam int DIV_EFF = (DIV < DIV_MIN) ? DIV_MIN : DIV;
  localparam int PW = $clog2(DIV_EFF);
  localparam logic [PW-1:0] LAST = PW'(DIV_EFF - 1);

  logic [PW-1:0] r_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (i_reload || (r_phase == LAST)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign o_phase_start = (r_phase == '0);
  assign o_phase_end   = (r_phase == LAST);

endmodule

// File: rtl/hc595_driver.sv
// Valid/ready word in, LSB-first SER/SRCLK/RCLK stream out for cascaded 595s.
//   state | meaning
//   IDLE  | READY high, pins idle, SER holds last bit
//   SETUP | SRCLK low, SER updated on first cycle
//   HIGH  | SRCLK high; exit is the shift edge
//   LATCH | RCLK high; exit is the latch edge
module hc595_driver
  import hc595_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_ser,
  output logic             o_srclk,
  output logic             o_rclk
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic             r_ready;
  logic             r_ser;
  logic             r_srclk;
  logic             r_rclk;

  logic             w_accept;
  logic             w_reload;
  logic             w_phase_start;
  logic             w_phase_end;
  logic [WIDTH:0]   w_shift;

  // READY is only ever high in IDLE, so it doubles as the idle qualifier.
  assign w_accept = r_ready && i_valid;
  assign w_reload = (r_state == IDLE);
  assign w_shift  = {1'b1, r_shreg} >> 1;

  hc595_phase #(
    .DIV(DIV)
  ) u_phase (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_reload     (w_reload),
    .o_phase_start(w_phase_start),
    .o_phase_end  (w_phase_end)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_shreg  <= '1;
      r_bitcnt <= '0;
      r_ready  <= 1'b1;
      r_ser    <= 1'b1;
      r_srclk  <= 1'b0;
      r_rclk   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg  <= i_din;
            r_bitcnt <= '0;
            r_ready  <= 1'b0;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          // SER moves one cycle after the shift edge, never on an SRCLK edge.
          if (w_phase_start) begin
            r_ser <= r_shreg[0];
          end
          if (w_phase_end) begin
            r_srclk <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_srclk  <= 1'b0;
            r_shreg  <= w_shift[WIDTH-1:0];
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == LAST_BIT) begin
              r_rclk  <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_state <= SETUP;
            end
          end
        end
        LATCH: begin
          if (w_phase_end) begin
            r_rclk  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_ser   = r_ser;
  assign o_srclk = r_srclk;
  assign o_rclk  = r_rclk;

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: behavioural 595 models, spec-timed waveform checks, scoreboard.
module tb_hc595_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din8;
  logic        valid8, ready8, ser8, srclk8, rclk8;
  logic [15:0] din16;
  logic        valid16, ready16, ser16, srclk16, rclk16;

  always #5 clk = ~clk;

  hc595_driver #(.WIDTH(8), .DIV(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din8), .i_valid(valid8),
    .o_ready(ready8), .o_ser(ser8), .o_srclk(srclk8), .o_rclk(rclk8)
  );

  hc595_driver #(.WIDTH(16), .DIV(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_din(din16), .i_valid(valid16),
    .o_ready(ready16), .o_ser(ser16), .o_srclk(srclk16), .o_rclk(rclk16)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // per-DUT monitor state, index 0 = 8-bit/DIV4, index 1 = 16-bit/DIV2
  int          acc_edge[2], last_fall[2], last_rise[2], last_rrise[2];
  int          falls[2], pulses[2], acc_cnt[2], done_cnt[2];
  int          f_falls[2], f_pulses[2], f_period[2];
  bit          in_fr[2];
  logic        p_ser[2], p_sr[2], p_rc[2], p_rdy[2];
  logic [15:0] sh[2], seq[2], f_seq[2], lat_out[2];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [7:0] exp_ser;    // SER at successive falls, first fall in bit 7
    int         exp_period;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon();
    logic        s_rdy, s_ser, s_sr, s_rc, s_val;
    logic [15:0] s_din, expw;
    int          w, dv;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      w     = (d == 0) ? 8 : 16;
      dv    = (d == 0) ? 4 : 2;
      s_rdy = (d == 0) ? ready8 : ready16;
      s_ser = (d == 0) ? ser8 : ser16;
      s_sr  = (d == 0) ? srclk8 : srclk16;
      s_rc  = (d == 0) ? rclk8 : rclk16;
      s_val = (d == 0) ? valid8 : valid16;
      s_din = (d == 0) ? {8'h00, din8} : din16;
      if (rst) begin
        in_fr[d] = 1'b0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        chk(!(s_rc && s_sr), "rclk_while_srclk", {30'd0, s_rc, s_sr}, 32'd0);
        if (s_ser != p_ser[d])
          chk(in_fr[d] && (cyc == last_fall[d] + 1), "ser_change_time", cyc, last_fall[d] + 1);
        if (s_sr && !p_sr[d]) begin
          chk(in_fr[d], "srclk_rise_outside_frame", cyc, acc_edge[d]);
          chk(cyc - last_fall[d] == dv, "srclk_low_width", cyc - last_fall[d], dv);
          chk(cyc - acc_edge[d] == 2 * falls[d] * dv + dv, "srclk_rise_time",
              cyc - acc_edge[d], 2 * falls[d] * dv + dv);
          last_rise[d] = cyc;
        end
        if (!s_sr && p_sr[d]) begin
          chk(cyc - last_rise[d] == dv, "srclk_high_width", cyc - last_rise[d], dv);
          chk(cyc - acc_edge[d] == 2 * (falls[d] + 1) * dv, "srclk_fall_time",
              cyc - acc_edge[d], 2 * (falls[d] + 1) * dv);
          sh[d]  = (sh[d] >> 1) | (16'(p_ser[d]) << (w - 1));
          seq[d] = {seq[d][14:0], p_ser[d]};
          falls[d]++;
          last_fall[d] = cyc;
        end
        if (s_rc && !p_rc[d]) begin
          chk(cyc - acc_edge[d] == 2 * w * dv, "rclk_rise_time", cyc - acc_edge[d], 2 * w * dv);
          last_rrise[d] = cyc;
          pulses[d]++;
        end
        if (!s_rc && p_rc[d]) begin
          chk(cyc - last_rrise[d] == dv, "rclk_width", cyc - last_rrise[d], dv);
          lat_out[d] = sh[d];
          if (d == 0) begin
            chk(exp_q0.size() != 0, "latch_without_frame", 32'(exp_q0.size()), 32'd1);
            if (exp_q0.size() != 0) begin
              expw = exp_q0.pop_front();
              chk(lat_out[d] == expw, "latch_word8", 32'(lat_out[d]), 32'(expw));
            end
          end else begin
            chk(exp_q1.size() != 0, "latch_without_frame", 32'(exp_q1.size()), 32'd1);
            if (exp_q1.size() != 0) begin
              expw = exp_q1.pop_front();
              chk(lat_out[d] == expw, "latch_word16", 32'(lat_out[d]), 32'(expw));
            end
          end
        end
        if (s_rdy && !p_rdy[d] && in_fr[d]) begin
          f_period[d] = cyc - acc_edge[d] + 1;
          f_falls[d]  = falls[d];
          f_pulses[d] = pulses[d];
          f_seq[d]    = seq[d];
          in_fr[d]    = 1'b0;
          done_cnt[d]++;
          chk(f_period[d] == (2 * w + 1) * dv + 1, "frame_period", f_period[d], (2 * w + 1) * dv + 1);
        end
        if (s_rdy && s_val) begin
          acc_edge[d]  = cyc + 1;
          last_fall[d] = cyc + 1;
          in_fr[d]     = 1'b1;
          falls[d]     = 0;
          pulses[d]    = 0;
          seq[d]       = '0;
          if (d == 0) exp_q0.push_back(s_din); else exp_q1.push_back(s_din);
          acc_cnt[d]++;
        end
      end
      p_ser[d] = s_ser;
      p_sr[d]  = s_sr;
      p_rc[d]  = s_rc;
      p_rdy[d] = s_rdy;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] word);
    int a0, n;
    a0 = acc_cnt[d];
    n  = 0;
    if (d == 0) begin valid8 = 1'b1; din8 = word[7:0]; end
    else begin valid16 = 1'b1; din16 = word; end
    while (acc_cnt[d] == a0 && n < 100) begin cycle(); n++; end
    chk(acc_cnt[d] != a0, "accept_timeout", 32'(n), 32'd100);
    if (d == 0) valid8 = 1'b0; else valid16 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[d] < target && n < budget) begin cycle(); n++; end
    chk(done_cnt[d] >= target, "frame_timeout", done_cnt[d], target);
  endtask

  initial begin
    logic [15:0] word;
    logic [15:0] prior;
    int          tgt, a0, n, first_acc;

    tbl[0] = '{8'hA5, 8'hA5, 8'b1010_0101, 69};
    tbl[1] = '{8'h3C, 8'h3C, 8'b0011_1100, 69};
    tbl[2] = '{8'h12, 8'h12, 8'b0100_1000, 69};
    tbl[3] = '{8'h80, 8'h80, 8'b0000_0001, 69};
    tbl[4] = '{8'h00, 8'h00, 8'b0000_0000, 69};

    sh[0] = '0; sh[1] = '0; lat_out[0] = '0; lat_out[1] = '0;
    rst = 1'b1; valid8 = 1'b0; din8 = '0; valid16 = 1'b0; din16 = '0;
    cycle();
    cycle();
    chk(ready8, "reset_ready", 32'(ready8), 32'd1);
    chk(ser8, "reset_ser", 32'(ser8), 32'd1);
    chk(!srclk8, "reset_srclk", 32'(srclk8), 32'd0);
    chk(!rclk8, "reset_rclk", 32'(rclk8), 32'd0);
    chk(ready16 && !srclk16, "reset_dut16", {30'd0, ready16, srclk16}, 32'd2);

    // VALID while in reset must not start a frame
    valid8 = 1'b1; din8 = 8'h55;
    repeat (3) cycle();
    chk(ready8 && !srclk8, "rst_overrides_valid", {30'd0, ready8, srclk8}, 32'd2);
    valid8 = 1'b0; rst = 1'b0;
    cycle();
    chk(ready8 && !srclk8, "idle_after_release", {30'd0, ready8, srclk8}, 32'd2);

    for (int i = 0; i < 5; i++) begin
      tgt = done_cnt[0] + 1;
      send(0, {8'h00, tbl[i].din});
      wait_done(0, tgt, 200);
      chk(lat_out[0][7:0] == tbl[i].exp_out, "tbl_latch", 32'(lat_out[0][7:0]), 32'(tbl[i].exp_out));
      chk(f_seq[0][7:0] == tbl[i].exp_ser, "tbl_ser_order", 32'(f_seq[0][7:0]), 32'(tbl[i].exp_ser));
      chk(f_falls[0] == 8, "tbl_srclk_falls", f_falls[0], 8);
      chk(f_pulses[0] == 1, "tbl_rclk_pulses", f_pulses[0], 1);
      chk(f_period[0] == tbl[i].exp_period, "tbl_ready_cycle", f_period[0], tbl[i].exp_period);
      repeat (3) cycle();
    end

    // back-to-back with VALID held high
    tgt = done_cnt[0];
    a0  = acc_cnt[0];
    valid8 = 1'b1; din8 = 8'h01;
    n = 0;
    while (acc_cnt[0] == a0 && n < 20) begin cycle(); n++; end
    chk(acc_cnt[0] == a0 + 1, "b2b_first_accept", acc_cnt[0] - a0, 1);
    first_acc = acc_edge[0];
    din8 = 8'hFF;
    n = 0;
    while (acc_cnt[0] == a0 + 1 && n < 100) begin cycle(); n++; end
    valid8 = 1'b0;
    chk(acc_cnt[0] == a0 + 2, "b2b_second_accept", acc_cnt[0] - a0, 2);
    chk(acc_edge[0] - first_acc == 69, "b2b_gap", acc_edge[0] - first_acc, 69);
    chk(lat_out[0][7:0] == 8'h01, "b2b_word1", 32'(lat_out[0][7:0]), 32'h01);
    wait_done(0, tgt + 2, 200);
    chk(lat_out[0][7:0] == 8'hFF, "b2b_word2", 32'(lat_out[0][7:0]), 32'hFF);

    // random VALID/DIN chatter while busy
    for (int f = 0; f < 10; f++) begin
      word = {8'h00, 8'($urandom)};
      tgt  = done_cnt[0] + 1;
      a0   = acc_cnt[0];
      send(0, word);
      for (int c = 0; c < 55; c++) begin
        valid8 = 1'($urandom_range(0, 1));
        din8   = 8'($urandom);
        cycle();
      end
      valid8 = 1'b0;
      chk(acc_cnt[0] == a0 + 1, "busy_accept_count", acc_cnt[0] - a0, 1);
      wait_done(0, tgt, 200);
      chk(lat_out[0][7:0] == word[7:0], "busy_latch", 32'(lat_out[0][7:0]), 32'(word[7:0]));
      chk(f_falls[0] == 8, "busy_srclk_falls", f_falls[0], 8);
    end

    // asynchronous reset while SRCLK is high after the third shift
    prior = lat_out[0];
    send(0, 16'h003C);
    n = 0;
    while (!(falls[0] == 3 && srclk8) && n < 100) begin cycle(); n++; end
    chk(falls[0] == 3 && srclk8, "rst_reach_point", falls[0], 3);
    rst = 1'b1;
    #1;
    chk(!srclk8, "rst_async_srclk", 32'(srclk8), 32'd0);
    chk(!rclk8, "rst_async_rclk", 32'(rclk8), 32'd0);
    chk(ready8, "rst_async_ready", 32'(ready8), 32'd1);
    chk(ser8, "rst_async_ser", 32'(ser8), 32'd1);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk(lat_out[0] == prior, "rst_keeps_outputs", 32'(lat_out[0]), 32'(prior));
    tgt = done_cnt[0] + 1;
    send(0, 16'h003C);
    wait_done(0, tgt, 200);
    chk(lat_out[0][7:0] == 8'h3C, "rst_next_frame", 32'(lat_out[0][7:0]), 32'h3C);

    // two cascaded chips, DIV=2
    tgt = done_cnt[1] + 1;
    send(1, 16'hBEEF);
    wait_done(1, tgt, 300);
    chk(lat_out[1][7:0] == 8'hEF, "cascade_low_chip", 32'(lat_out[1][7:0]), 32'hEF);
    chk(lat_out[1][15:8] == 8'hBE, "cascade_high_chip", 32'(lat_out[1][15:8]), 32'hBE);
    chk(f_period[1] == 67, "cascade_ready_cycle", f_period[1], 67);
    chk(f_falls[1] == 16, "cascade_srclk_falls", f_falls[1], 16);
    for (int f = 0; f < 4; f++) begin
      word = 16'($urandom);
      tgt  = done_cnt[1] + 1;
      send(1, word);
      wait_done(1, tgt, 300);
      chk(lat_out[1] == word, "cascade_random", 32'(lat_out[1]), 32'(word));
    end

    repeat (4) cycle();
    chk(exp_q0.size() == 0 && exp_q1.size() == 0, "scoreboard_drained",
        32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
